// File: rtl/clause_table_mp.sv
// Append-ordered clause index table with NUM_RD registered random-access read ports and truncate-on-backtrack.
// Reads and push/truncate resolve every cycle with 1-cycle latency; there is no backpressure, and errors are flagged instead.
module clause_table_mp #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 16,
  parameter int NUM_RD = 2,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_W-1:0]         clause_in,
  input  logic                      truncate,
  input  logic [CNT_W-1:0]          trunc_count,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [NUM_RD*IDX_W-1:0]   rd_index,
  output logic [NUM_RD*DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]         rd_valid,
  output logic [NUM_RD-1:0]         rd_error,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      push_error,
  output logic                      trunc_error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [CNT_W-1:0]         count_q, count_d, eff_cnt;
  logic                     trunc_ok, push_ok;
  logic                     push_error_q, push_error_d;
  logic                     trunc_error_q, trunc_error_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_valid_q, rd_valid_d;
  logic [NUM_RD-1:0]        rd_error_q, rd_error_d;
  logic [IDX_W-1:0]         rd_idx;

  // Truncate resolves first; push then appends at the effective count.
  always_comb begin
    trunc_ok      = (trunc_count <= count_q);
    eff_cnt       = (truncate && trunc_ok) ? trunc_count : count_q;
    trunc_error_d = truncate && !trunc_ok;
    push_ok       = push && (eff_cnt < DEPTH_C);
    push_error_d  = push && !push_ok;
    count_d       = push_ok ? (eff_cnt + CNT_W'(1)) : eff_cnt;
  end

  // Reads compare against the pre-update count and see pre-update memory.
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = '0;
    rd_error_d = '0;
    rd_idx     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_idx = rd_index[p*IDX_W +: IDX_W];
      if (rd_en[p]) begin
        if (CNT_W'(rd_idx) < count_q) begin
          rd_valid_d[p]                  = 1'b1;
          rd_data_d[p*DATA_W +: DATA_W]  = mem_q[rd_idx];
        end else begin
          rd_error_d[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      push_error_q  <= 1'b0;
      trunc_error_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= '0;
      rd_error_q    <= '0;
    end else begin
      count_q       <= count_d;
      push_error_q  <= push_error_d;
      trunc_error_q <= trunc_error_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      rd_error_q    <= rd_error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      mem_q[eff_cnt[IDX_W-1:0]] <= clause_in;
    end
  end

  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign push_error  = push_error_q;
  assign trunc_error = trunc_error_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_error    = rd_error_q;

endmodule

// File: tb/tb_clause_table_mp.sv
// Directed table-driven bench for clause_table_mp at DEPTH=8, two read ports.
module tb_clause_table_mp;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int NUM_RD = 2;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 4;
  localparam int NVEC   = 20;

  logic                     clock;
  logic                     reset;
  logic                     push;
  logic [DATA_W-1:0]        clause_in;
  logic                     truncate;
  logic [CNT_W-1:0]         trunc_count;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*IDX_W-1:0]  rd_index;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_RD-1:0]        rd_error;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     push_error;
  logic                     trunc_error;

  int checks = 0;
  int errors = 0;

  clause_table_mp #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_RD(NUM_RD)
  ) dut (
    .clock(clock), .reset(reset), .push(push), .clause_in(clause_in),
    .truncate(truncate), .trunc_count(trunc_count), .rd_en(rd_en),
    .rd_index(rd_index), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_error(rd_error), .count(count), .full(full),
    .push_error(push_error), .trunc_error(trunc_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic              push;
    logic [DATA_W-1:0] din;
    logic              trunc;
    logic [CNT_W-1:0]  tcnt;
    logic [1:0]        en;
    logic [IDX_W-1:0]  i0;
    logic [IDX_W-1:0]  i1;
    logic [CNT_W-1:0]  cnt;
    logic              full;
    logic              perr;
    logic              terr;
    logic [1:0]        vld;
    logic [1:0]        err;
    logic [DATA_W-1:0] d0;
    logic [DATA_W-1:0] d1;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(int pu, int din, int tr, int tc, int en, int i0, int i1,
                              int cnt, int fl, int pe, int te, int vld, int err,
                              int d0, int d1);
    vec_t v;
    v.push = 1'(pu);   v.din = 16'(din); v.trunc = 1'(tr); v.tcnt = 4'(tc);
    v.en   = 2'(en);   v.i0  = 3'(i0);   v.i1    = 3'(i1);
    v.cnt  = 4'(cnt);  v.full = 1'(fl);  v.perr  = 1'(pe);  v.terr = 1'(te);
    v.vld  = 2'(vld);  v.err  = 2'(err); v.d0    = 16'(d0); v.d1   = 16'(d1);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic pu, input int din, input logic tr, input int tc,
                       input logic [1:0] en, input int i0, input int i1);
    push        = pu;
    clause_in   = 16'(din);
    truncate    = tr;
    trunc_count = 4'(tc);
    rd_en       = en;
    rd_index    = {3'(i1), 3'(i0)};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Vectors: each is applied for one cycle and checked 1 time unit after the edge.
    vecs[0] = mk(0, 0, 0, 0, 3, 0, 5,   0, 0, 0, 0, 0, 3,  0,  0);
    for (int i = 0; i < 8; i++)
      vecs[1+i] = mk(1, 10+i, 0, 0, 0, 0, 0,  i+1, (i == 7) ? 1 : 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 99, 0, 0, 3, 7, 0,  8, 1, 1, 0, 3, 0, 17, 10);
    vecs[10] = mk(0,  0, 0, 0, 3, 7, 7,  8, 1, 0, 0, 3, 0, 17, 17);
    vecs[11] = mk(1, 77, 1, 3, 3, 2, 3,  4, 0, 0, 0, 3, 0, 12, 13);
    vecs[12] = mk(0,  0, 0, 0, 3, 3, 4,  4, 0, 0, 0, 1, 2, 77,  0);
    vecs[13] = mk(1, 55, 1, 6, 0, 0, 0,  5, 0, 0, 1, 0, 0,  0,  0);
    vecs[14] = mk(0,  0, 0, 0, 3, 4, 5,  5, 0, 0, 0, 1, 2, 55,  0);
    vecs[15] = mk(0,  0, 0, 0, 3, 2, 2,  5, 0, 0, 0, 3, 0, 12, 12);
    vecs[16] = mk(1, 40, 0, 0, 3, 5, 0,  6, 0, 0, 0, 2, 1,  0, 10);
    vecs[17] = mk(0,  0, 0, 0, 1, 5, 0,  6, 0, 0, 0, 1, 0, 40,  0);
    vecs[18] = mk(0,  0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0, 10,  0);
    vecs[19] = mk(0,  0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1,  0,  0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 2'b00, 0, 0);
    #2;
    check("reset_count", int'(count), 0);
    check("reset_full", int'(full), 0);
    check("reset_valid", int'(rd_valid), 0);
    check("reset_error", int'(rd_error), 0);
    check("reset_data", int'(rd_data), 0);
    check("reset_perr", int'(push_error), 0);
    check("reset_terr", int'(trunc_error), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].push, int'(vecs[v].din), vecs[v].trunc, int'(vecs[v].tcnt),
            vecs[v].en, int'(vecs[v].i0), int'(vecs[v].i1));
      step();
      check($sformatf("v%0d_count", v), int'(count), int'(vecs[v].cnt));
      check($sformatf("v%0d_full", v), int'(full), int'(vecs[v].full));
      check($sformatf("v%0d_perr", v), int'(push_error), int'(vecs[v].perr));
      check($sformatf("v%0d_terr", v), int'(trunc_error), int'(vecs[v].terr));
      check($sformatf("v%0d_valid", v), int'(rd_valid), int'(vecs[v].vld));
      check($sformatf("v%0d_rderr", v), int'(rd_error), int'(vecs[v].err));
      check($sformatf("v%0d_data0", v), int'(rd_data[15:0]), int'(vecs[v].d0));
      check($sformatf("v%0d_data1", v), int'(rd_data[31:16]), int'(vecs[v].d1));
    end

    // Refill from empty, then truncate out of the full state and push in the same cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1, 20+i, 0, 0, 2'b00, 0, 0);
      step();
    end
    check("refill_count", int'(count), 8);
    check("refill_full", int'(full), 1);
    drive(1, 5, 1, 7, 2'b00, 0, 0);
    step();
    check("trfull_count", int'(count), 8);
    check("trfull_perr", int'(push_error), 0);
    drive(0, 0, 0, 0, 2'b11, 7, 6);
    step();
    check("trfull_rd7", int'(rd_data[15:0]), 5);
    check("trfull_rd6", int'(rd_data[31:16]), 26);
    check("trfull_vld", int'(rd_valid), 3);

    // Truncating to the current count at full does not free space.
    drive(1, 9, 1, 8, 2'b00, 0, 0);
    step();
    check("treq_count", int'(count), 8);
    check("treq_perr", int'(push_error), 1);
    check("treq_terr", int'(trunc_error), 0);

    // Async reset mid-cycle clears outputs before the next edge and drops that cycle's push.
    drive(0, 0, 0, 0, 2'b01, 0, 0);
    step();
    check("prerst_vld", int'(rd_valid), 1);
    check("prerst_data", int'(rd_data[15:0]), 20);
    drive(1, 33, 0, 0, 2'b01, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_full", int'(full), 0);
    check("arst_vld", int'(rd_valid), 0);
    check("arst_data", int'(rd_data), 0);
    step();
    check("arst_hold_count", int'(count), 0);
    check("arst_hold_vld", int'(rd_valid), 0);
    @(negedge clock);
    reset = 1'b0;
    drive(1, 44, 0, 0, 2'b01, 0, 0);
    step();
    check("post_rst_count", int'(count), 1);
    check("post_rst_rderr", int'(rd_error), 1);
    drive(0, 0, 0, 0, 2'b01, 0, 0);
    step();
    check("post_rst_rd0", int'(rd_data[15:0]), 44);
    check("post_rst_vld", int'(rd_valid), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clause_table_mp.md
# clause_table_mp

Parametrised, multi-read-port successor to the solver's clause table. It stores clause indices in append order, serves `NUM_RD` independent registered random-access reads per cycle, and supports truncation back to an earlier entry count so the control logic can discard learned clauses on backtrack. It sits between the clause-learning/assignment controller (pushes, truncates) and the parallel BCP/watch units (reads).

## Interface
- `DEPTH`, default 64: number of entries; any value ≥ 2.
- `DATA_W`, default 16: width of a stored clause index.
- `NUM_RD`, default 2: number of independent read ports, ≥ 1.
- `IDX_W`, default $clog2(DEPTH): read index width (derived).
- `CNT_W`, default $clog2(DEPTH+1): entry count width (derived).

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `push`  in  1  append `clause_in` at position `count`.
- `clause_in`  in  DATA_W  value to append.
- `truncate`  in  1  set the entry count to `trunc_count`.
- `trunc_count`  in  CNT_W  new entry count; must be ≤ current `count`.
- `rd_en`  in  NUM_RD  per-port read request.
- `rd_index`  in  NUM_RD*IDX_W  per-port index; port p uses bits [p*IDX_W +: IDX_W].
- `rd_data`  out  NUM_RD*DATA_W  per-port read data, packed the same way as `rd_index`.
- `rd_valid`  out  NUM_RD  `rd_data[p]` holds a valid entry.
- `rd_error`  out  NUM_RD  the read on port p targeted an index ≥ `count`.
- `count`  out  CNT_W  current number of valid entries.
- `full`  out  1  `count == DEPTH`, combinational from `count`.
- `push_error`  out  1  a push was dropped because the table was full.
- `trunc_error`  out  1  a truncate was ignored because `trunc_count > count`.

## Operation
- Valid entries occupy positions 0..count-1. Storage array is not reset; positions at or above `count` are don't-care.
- Truncate is evaluated first:
  - Legal when `trunc_count ≤ count`. The effective count becomes `trunc_count`.
  - Illegal when `trunc_count > count`. The effective count stays `count`, and `trunc_error` is set.
- Push is evaluated against the effective count:
  - When effective count < DEPTH: write `mem[eff] <= clause_in`, and `count <= eff + 1`.
  - Otherwise: no write, `count <= eff`, and `push_error` is set.
  - Push combined with a legal truncate therefore overwrites at `trunc_count`. This is the backtrack-then-learn case. A truncate from `count == DEPTH` frees space for a push in the same cycle.
- Reads on each port p:
  - Compare `rd_index[p]` against the pre-update `count`, i.e. the count before this edge.
  - Reads see pre-update memory, so there is no write-through. A read at index == `count` during a push is an error.
  - Hit (`rd_en[p]` and index < count): `rd_valid[p] <= 1`, `rd_data[p] <= mem[index]`, `rd_error[p] <= 0`.
  - Miss (`rd_en[p]` and index ≥ count): `rd_error[p] <= 1`, `rd_valid[p] <= 0`, `rd_data[p] <= 0`.
  - Idle (`!rd_en[p]`): `rd_valid`, `rd_error` and `rd_data` for that port go to 0.
- Ports are fully independent. Multiple ports may read the same index in the same cycle.
- `push_error` and `trunc_error` are single-cycle pulses: registered, and cleared on the next edge unless the condition recurs.

## Timing
- Reset (async, immediate, no clock needed): `count=0`, `full=0`, `rd_data=0`, `rd_valid=0`, `rd_error=0`, `push_error=0`, `trunc_error=0`.
- Reset asserted mid-operation discards any in-flight read and the push/truncate of that cycle.
- First operation is accepted at the first rising edge after `reset` deasserts.
- Read latency is 1 cycle: request at edge N, result visible after edge N, held for one cycle.
- Push/truncate latency:
  - `count`/`full` update after the accepting edge.
  - A read issued in the following cycle sees the new entry.
- Error flags are visible the cycle after the offending request.
- No backpressure or handshake. Every request is resolved in its cycle.

## Test plan
- **Reset, then empty read.** Reset, then `rd_en=2'b11`, indices 0 and 5. Expect `rd_error=2'b11`, `rd_valid=0`, `rd_data=0`, `count=0`.
- **Fill and overflow** (DEPTH=8). Push values 10..17 (8 pushes): `count` reaches 8, `full=1`. A 9th push of 99 gives `push_error=1` for one cycle, `count=8`, and reading index 7 still returns 17.
- **Bounds and multi-port.** With 5 entries (10..14):
  - Port0 reads idx 4 → 14 with valid.
  - Port1 reads idx 5 → `rd_error=1` in the same cycle.
  - Both ports reading idx 2 → both return 12.
- **Truncate + push, same cycle.** With 8 entries, `truncate` with `trunc_count=3` and push 77 together. Expect `count=4` and idx 3 reads 77. A following read of idx 4 errors.
- **Illegal truncate.** With `count=4`, truncate to 6 and push 55 together. Expect `trunc_error=1`, `count=5`, and idx 4 reads 55.
- **Read during push, and async reset.**
  - With `count=5`, push 40 while port0 reads idx 5. Expect `rd_error=1`; the next-cycle read of idx 5 returns 40.
  - Assert `reset` mid-cycle. Outputs go to 0 before the next edge.
